// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - dual-issue IF-to-decode instruction queue; optional perf counters via FETCH_BUF_PERF_EN
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_buf_flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic        if_inst1_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst0,
  input  logic [31:0] if_inst1,
  output logic        fifo_valid,
  input  logic        fifo_ready,
  output logic        fifo_inst1_valid,
  output logic [31:0] inst0_o,
  output logic [31:0] inst1_o,
  output logic [31:0] pc0_o,
  output logic [31:0] pc1_o,
`ifdef FETCH_BUF_PERF_EN
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_empty_cycles,
`endif
  output logic        fetch_buf_empty,
  output logic        fetch_buf_full
);

  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  logic [31:0]    mem_pc   [DEPTH];
  logic [31:0]    mem_inst [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
  logic [PTR_W:0]   count;
  logic             push, pop;
  logic [1:0]       push_n, pop_n;

  assign rd_ptr1 = rd_ptr + PTR_W'(1);
  assign wr_ptr1 = wr_ptr + PTR_W'(1);

  // Ready looks only at the registered count; a same-cycle pop is never credited.
  assign if_ready         = (count <= READY_MAX);
  assign fetch_buf_full   = !if_ready;
  assign fetch_buf_empty  = (count == '0);
  assign fifo_valid       = (count != '0);
  assign fifo_inst1_valid = (count >= (PTR_W+1)'(2));

  assign push   = if_valid && if_ready && !fetch_buf_flush;
  assign pop    = fifo_valid && fifo_ready && !fetch_buf_flush;
  assign push_n = push ? (if_inst1_valid ? 2'd2 : 2'd1) : 2'd0;
  assign pop_n  = pop ? (fifo_inst1_valid ? 2'd2 : 2'd1) : 2'd0;

  assign inst0_o = fifo_valid       ? mem_inst[rd_ptr]  : `INST_NOP;
  assign pc0_o   = fifo_valid       ? mem_pc[rd_ptr]    : 32'd0;
  assign inst1_o = fifo_inst1_valid ? mem_inst[rd_ptr1] : `INST_NOP;
  assign pc1_o   = fifo_inst1_valid ? mem_pc[rd_ptr1]   : 32'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= if_pc;
      mem_inst[wr_ptr] <= if_inst0;
      if (if_inst1_valid) begin
        mem_pc[wr_ptr1]   <= if_pc + 32'd4;
        mem_inst[wr_ptr1] <= if_inst1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (fetch_buf_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      count  <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    end
  end

`ifdef FETCH_BUF_PERF_EN
  // Counters survive flush so stall statistics span mispredicts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (if_valid && !if_ready)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if (fetch_buf_empty && !fetch_buf_flush)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed self-checking bench for fetch_buffer
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_buf_flush;
  logic        if_valid;
  logic        if_ready;
  logic        if_inst1_valid;
  logic [31:0] if_pc, if_inst0, if_inst1;
  logic        fifo_valid, fifo_ready, fifo_inst1_valid;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic        fetch_buf_empty, fetch_buf_full;
`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_full_cycles, perf_empty_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rd_seq, wr_seq;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(8)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .fetch_buf_flush  (fetch_buf_flush),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_inst1_valid   (if_inst1_valid),
    .if_pc            (if_pc),
    .if_inst0         (if_inst0),
    .if_inst1         (if_inst1),
    .fifo_valid       (fifo_valid),
    .fifo_ready       (fifo_ready),
    .fifo_inst1_valid (fifo_inst1_valid),
    .inst0_o          (inst0_o),
    .inst1_o          (inst1_o),
    .pc0_o            (pc0_o),
    .pc1_o            (pc1_o),
`ifdef FETCH_BUF_PERF_EN
    .perf_full_cycles (perf_full_cycles),
    .perf_empty_cycles(perf_empty_cycles),
`endif
    .fetch_buf_empty  (fetch_buf_empty),
    .fetch_buf_full   (fetch_buf_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid        = 1'b0;
    if_inst1_valid  = 1'b0;
    fifo_ready      = 1'b0;
    fetch_buf_flush = 1'b0;
  endtask

  task automatic drive_pkt(input logic [31:0] pc, input logic [31:0] i0,
                           input logic [31:0] i1, input logic v1);
    if_valid       = 1'b1;
    if_pc          = pc;
    if_inst0       = i0;
    if_inst1       = i1;
    if_inst1_valid = v1;
  endtask

  initial begin
    idle();
    if_pc = '0; if_inst0 = '0; if_inst1 = '0;
    rstn = 1'b0;
    tick();
    check("rst_fifo_valid", 32'(fifo_valid), 32'd0);
    check("rst_empty",      32'(fetch_buf_empty), 32'd1);
    check("rst_full",       32'(fetch_buf_full), 32'd0);
    check("rst_if_ready",   32'(if_ready), 32'd1);
    check("rst_inst0_nop",  inst0_o, `INST_NOP);
    check("rst_pc0",        pc0_o, 32'd0);
    rstn = 1'b1;
    tick();

    // first 2-instruction packet, no consumption
    drive_pkt(32'h1c000000, 32'hA, 32'hB, 1'b1);
    tick();
    idle();
    check("p2_fifo_valid", 32'(fifo_valid), 32'd1);
    check("p2_inst1_valid", 32'(fifo_inst1_valid), 32'd1);
    check("p2_inst0", inst0_o, 32'hA);
    check("p2_pc0",   pc0_o, 32'h1c000000);
    check("p2_inst1", inst1_o, 32'hB);
    check("p2_pc1",   pc1_o, 32'h1c000004);
    check("p2_empty", 32'(fetch_buf_empty), 32'd0);
    fifo_ready = 1'b1;
    tick();
    idle();
    check("p2_drained", 32'(fetch_buf_empty), 32'd1);

    // single-instruction packet
    drive_pkt(32'h1c000008, 32'hC, 32'hFFFF, 1'b0);
    tick();
    idle();
    check("p1_inst1_valid", 32'(fifo_inst1_valid), 32'd0);
    check("p1_inst0", inst0_o, 32'hC);
    check("p1_inst1_nop", inst1_o, `INST_NOP);
    check("p1_pc1", pc1_o, 32'd0);
    fifo_ready = 1'b1;
    tick();
    idle();
    check("p1_empty", 32'(fetch_buf_empty), 32'd1);

    // fill to DEPTH; pointers start at 3 so the fill straddles the wrap
    for (int k = 0; k < 4; k++) begin
      drive_pkt(32'h2000 + 32'(8*k), 32'h100 + 32'(2*k), 32'h101 + 32'(2*k), 1'b1);
      tick();
    end
    idle();
    check("fill_full", 32'(fetch_buf_full), 32'd1);
    check("fill_if_ready", 32'(if_ready), 32'd0);
    drive_pkt(32'h9000, 32'hDEAD, 32'hBEEF, 1'b1);
    tick();
    idle();
    for (int j = 0; j < 4; j++) begin
      check("fill_inst0", inst0_o, 32'h100 + 32'(2*j));
      check("fill_inst1", inst1_o, 32'h101 + 32'(2*j));
      check("fill_pc1",   pc1_o, 32'h2004 + 32'(8*j));
      fifo_ready = 1'b1;
      // with a pop pending at count 8, ready must still be low
      if (j == 0) check("fill_no_credit", 32'(if_ready), 32'd0);
      tick();
      idle();
    end
    check("fill_empty_after", 32'(fetch_buf_empty), 32'd1);

    // steady state: count held at 4, push 2 and pop 2 every cycle
    wr_seq = 0;
    rd_seq = 0;
    for (int k = 0; k < 2; k++) begin
      drive_pkt(32'h4000 + 32'(4*wr_seq), 32'h300 + 32'(wr_seq), 32'h301 + 32'(wr_seq), 1'b1);
      wr_seq += 2;
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      check("ss_inst0", inst0_o, 32'h300 + 32'(rd_seq));
      check("ss_inst1", inst1_o, 32'h301 + 32'(rd_seq));
      check("ss_pc0",   pc0_o, 32'h4000 + 32'(4*rd_seq));
      check("ss_ready", 32'(if_ready), 32'd1);
      drive_pkt(32'h4000 + 32'(4*wr_seq), 32'h300 + 32'(wr_seq), 32'h301 + 32'(wr_seq), 1'b1);
      fifo_ready = 1'b1;
      wr_seq += 2;
      rd_seq += 2;
      tick();
    end
    idle();
    check("ss_inst0_end", inst0_o, 32'h300 + 32'(rd_seq));

    // count 4 -> 5, then flush with push and pop requested
    drive_pkt(32'h5000, 32'h500, 32'h0, 1'b0);
    tick();
    drive_pkt(32'h6000, 32'h600, 32'h601, 1'b1);
    fifo_ready      = 1'b1;
    fetch_buf_flush = 1'b1;
    tick();
    idle();
    check("fl_fifo_valid", 32'(fifo_valid), 32'd0);
    check("fl_empty", 32'(fetch_buf_empty), 32'd1);
    check("fl_inst0_nop", inst0_o, `INST_NOP);
    tick();
    check("fl_pkt_dropped", 32'(fifo_valid), 32'd0);

    // async reset with 6 entries queued
    for (int k = 0; k < 3; k++) begin
      drive_pkt(32'h7000 + 32'(8*k), 32'h700 + 32'(2*k), 32'h701 + 32'(2*k), 1'b1);
      tick();
    end
    idle();
    check("ar_pre_inst0", inst0_o, 32'h700);
    check("ar_pre_ready", 32'(if_ready), 32'd1);
    rstn = 1'b0;
    #2;
    check("ar_fifo_valid", 32'(fifo_valid), 32'd0);
    check("ar_empty", 32'(fetch_buf_empty), 32'd1);
`ifdef FETCH_BUF_PERF_EN
    check("ar_perf_full", perf_full_cycles, 32'd0);
    check("ar_perf_empty", perf_empty_cycles, 32'd0);
`endif
    tick();
    rstn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Dual-issue instruction queue between the IF stage and the FIFO/ID pipeline register; it is the sender side of the fifo_valid/fifo_ready handshake.
- Accepts fetch packets of 1 or 2 instructions (with PCs) from IF.
- Presents up to two oldest instructions per cycle to the decode side.
- Reports empty/full status.

Parameters:
- DEPTH, 8, number of instruction entries; power of 2, >= 4.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- fetch_buf_flush  input  1  clear all entries (branch mispredict/exception).
- if_valid  input  1  IF packet valid.
- if_ready  output  1  buffer can accept a 2-instruction packet.
- if_inst1_valid  input  1  packet carries a second instruction.
- if_pc  input  32  PC of first packet instruction; second instruction is if_pc+4.
- if_inst0  input  32  first instruction.
- if_inst1  input  32  second instruction.
- fifo_valid  output  1  at least one instruction available.
- fifo_ready  input  1  downstream consumes this cycle.
- fifo_inst1_valid  output  1  second output slot holds a real instruction.
- inst0_o  output  32  oldest instruction.
- inst1_o  output  32  second-oldest instruction.
- pc0_o  output  32  PC of inst0_o.
- pc1_o  output  32  PC of inst1_o.
- fetch_buf_empty  output  1  count == 0.
- fetch_buf_full  output  1  free entries < 2.

Behaviour:
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}.
- State: rd_ptr and wr_ptr (PTR_W bits, wrap modulo DEPTH); count (PTR_W+1 bits, 0..DEPTH).
- Reset (async, rstn low): rd_ptr=0, wr_ptr=0, count=0, so fifo_valid=0, fetch_buf_empty=1, fetch_buf_full=0, if_ready=1. Entry contents are don't-care. Reset asserted mid-operation discards all contents immediately.
- if_ready = (DEPTH - count) >= 2. It is computed from the current count only; same-cycle pops are not credited. fetch_buf_full = !if_ready.
- Push when if_valid && if_ready && !fetch_buf_flush:
  - write {if_pc, if_inst0} at wr_ptr;
  - if if_inst1_valid, also write {if_pc+4, if_inst1} at wr_ptr+1 (wraps);
  - push_n = 1 + if_inst1_valid.
- Read side is show-ahead and combinational from storage:
  - inst0_o/pc0_o = entry[rd_ptr];
  - inst1_o/pc1_o = entry[rd_ptr+1] (wraps).
- fifo_valid = count >= 1. fifo_inst1_valid = count >= 2.
- Output masking: inst0_o = `INST_NOP and pc0_o = 0 when !fifo_valid; inst1_o = `INST_NOP and pc1_o = 0 when !fifo_inst1_valid. `INST_NOP comes from define.vh.
- Pop when fifo_valid && fifo_ready && !fetch_buf_flush: pop_n = fifo_inst1_valid ? 2 : 1. The decode side always consumes every valid slot presented.
- Update: count <= count + push_n - pop_n; rd_ptr += pop_n; wr_ptr += push_n. Simultaneous push and pop are both honoured in the same cycle.
- Latency: an instruction pushed in cycle N is visible on the outputs in cycle N+1 (no bypass).
- Flush has priority over push and pop. On the next edge: rd_ptr=wr_ptr=0, count=0. The IF packet presented in the flush cycle is dropped.
- Boundaries:
  - count==DEPTH-1 gives if_ready=0, even if a pop occurs that cycle.
  - Pointer wrap from DEPTH-1 to 0 is seamless, including a 2-instruction push or pop straddling the wrap.
  - if_valid while !if_ready: nothing is written; IF holds the packet.

Optional Feature:
- Macro FETCH_BUF_PERF_EN.
- Defined:
  - adds outputs perf_full_cycles[31:0] and perf_empty_cycles[31:0];
  - perf_full_cycles increments each cycle with if_valid && !if_ready;
  - perf_empty_cycles increments each cycle with count==0 && !fetch_buf_flush;
  - both are reset to 0 by rstn only (not by flush) and wrap at 2^32.
- Undefined: ports and counters absent; no functional change.

Test Plan:
- Reset, then push {pc=0x1c000000, inst0=0xA, inst1=0xB, inst1_valid=1} with fifo_ready=0 -> next cycle fifo_valid=1, fifo_inst1_valid=1, inst0_o=0xA, pc0_o=0x1c000000, inst1_o=0xB, pc1_o=0x1c000004, fetch_buf_empty=0.
- Single push with inst1_valid=0 (inst0=0xC) -> fifo_inst1_valid=0, inst1_o=`INST_NOP, pc1_o=0. Then fifo_ready=1 for one cycle -> fetch_buf_empty=1.
- Fill with fifo_ready=0 (DEPTH=8, four 2-instruction pushes) -> count=8, fetch_buf_full=1, if_ready=0. A fifth if_valid packet is not written; contents stay in order 0..7.
- Steady state with 2-instruction push and 2-instruction pop every cycle for 20 cycles -> count constant, outputs in strict program order across pointer wraps, no drops or duplicates.
- With count=5, assert fetch_buf_flush together with if_valid and fifo_ready -> next cycle count=0, fifo_valid=0, inst0_o=`INST_NOP; the flushed-cycle packet is absent.
- Assert rstn low mid-stream (count=6) -> fifo_valid=0 and fetch_buf_empty=1 immediately, without waiting for a clock edge. With FETCH_BUF_PERF_EN, perf counters read 0.
